pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Next-PC selection and pipeline stall/flush control for a single-issue core.
// Handles load-use hazards, multi-cycle mul/div stalls, exceptions and exception return.
module pc_sequencer #(
  parameter logic [31:0] PC_START_ADDR = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR    = 32'h0040_0004,
  parameter int unsigned MD_CYCLES     = 32
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] pc_cur_i,
  input  logic        ex_mem_read_i,
  input  logic [4:0]  ex_rt_i,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        jmp_i,
  input  logic [31:0] jmp_target_i,
  input  logic        exc_i,
  input  logic        eret_i,
  input  logic [31:0] epc_i,
  input  logic        md_start_i,
  output logic [31:0] pc_next_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic        busy_o,
  output logic [1:0]  state_o,
  output logic [31:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MD_WAIT   = 2'd1,
    EXC_FLUSH = 2'd2,
    ILLEGAL   = 2'd3
  } state_t;

  // Counter reload value: MD_WAIT lasts for counts MD_CYCLES-1 down to 0.
  localparam logic [7:0] MD_LOAD = 8'(MD_CYCLES - 1);

  state_t      state, state_nxt;
  logic [7:0]  md_cnt, md_cnt_nxt;
  logic [31:0] stall_cnt;
  logic        hazard;
  logic [31:0] pc_plus4;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign hazard   = ex_mem_read_i && (ex_rt_i != 5'd0) &&
                    ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));
  assign pc_plus4 = pc_cur_i + 32'd4;

  // State register, mul/div down-counter and stall statistics
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= RUN;
      md_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
      if (stall_o) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    unique case (state)
      RUN: begin
        if (exc_i) begin
          state_nxt = EXC_FLUSH;
        end else if (md_start_i) begin
          state_nxt  = MD_WAIT;
          md_cnt_nxt = MD_LOAD;
        end
      end
      MD_WAIT: begin
        if (exc_i) begin
          state_nxt  = EXC_FLUSH;
          md_cnt_nxt = '0;
        end else if (md_cnt == 8'd0) begin
          state_nxt = RUN;
        end else begin
          md_cnt_nxt = md_cnt - 8'd1;
        end
      end
      EXC_FLUSH: state_nxt = exc_i ? EXC_FLUSH : RUN;
      default: begin
        state_nxt  = RUN;
        md_cnt_nxt = '0;
      end
    endcase
  end

  // Outputs are forced to their idle values while reset is held, whatever the inputs do.
  always_comb begin
    stall_o   = 1'b0;
    flush_o   = 1'b0;
    pc_next_o = PC_START_ADDR;
    if (rst_n_i) begin
      stall_o = !exc_i && (((state == RUN) && hazard) || (state == MD_WAIT));
      flush_o = exc_i || eret_i || (state == EXC_FLUSH);
      if (exc_i)                    pc_next_o = EXC_VECTOR;
      else if (eret_i)              pc_next_o = epc_i;
      else if (stall_o)             pc_next_o = pc_cur_i;
      else if (state == EXC_FLUSH)  pc_next_o = pc_plus4;
      else if (br_taken_i)          pc_next_o = br_target_i;
      else if (jmp_i)               pc_next_o = jmp_target_i;
      else                          pc_next_o = pc_plus4;
    end
  end

  assign busy_o      = (state == MD_WAIT);
  assign state_o     = state;
  assign stall_cnt_o = stall_cnt;

endmodule
